// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package program_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR_HI = 3'd1,
      HDR_LO = 3'd2,
      LOAD   = 3'd3,
      WRITE  = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, program-memory write bus out.
interface program_loader_if #(
   parameter int AW = 5
);
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Shifts stream bytes MSB-first into a 32-bit word and flags the 4th byte.
module program_loader_word_assembler
   import program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_complete
);
   logic [31:0] word_reg;
   logic [1:0]  idx_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_reg <= 32'd0;
         idx_reg  <= 2'd0;
      end else if (clear) begin
         idx_reg  <= 2'd0;
      end else if (shift_en) begin
         word_reg <= {word_reg[23:0], byte_in};
         idx_reg  <= idx_reg + 2'd1;
      end
   end

   assign word          = word_reg;
   assign word_complete = shift_en && (idx_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> sequential program-memory words,
// holding the processor in reset until the final word has been written.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int MEMORY_DEPTH = 32,
   parameter int AW           = $clog2(MEMORY_DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   program_loader_if.slave        bus,
   output logic                   cpu_reset,
   output logic                   done,
   output logic                   error
);
   state_t        state_reg, state_next;
   logic [15:0]   count_reg;
   logic [AW:0]   word_idx_reg;
   logic [AW:0]   word_idx_inc;
   logic [AW-1:0] wr_addr_reg;
   logic [31:0]   wr_data_reg;
   logic [31:0]   asm_word;
   logic          word_complete;
   logic [15:0]   hdr_count;
   logic          ready;
   logic          accept;
   logic          last_word;

   assign accept       = bus.byte_valid && ready;
   assign hdr_count    = {count_reg[15:8], bus.byte_data};
   assign word_idx_inc = word_idx_reg + 1'b1;
   assign last_word    = (16'(word_idx_inc) == count_reg);

   program_loader_word_assembler u_asm (
      .clk           (clk),
      .rst           (reset),
      .clear         (state_reg == HDR_LO),
      .shift_en      (accept && (state_reg == LOAD)),
      .byte_in       (bus.byte_data),
      .word          (asm_word),
      .word_complete (word_complete)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE, ERROR: if (start) state_next = HDR_HI;
         HDR_HI:            if (accept) state_next = HDR_LO;
         HDR_LO: begin
            if (accept) begin
               if (hdr_count == 16'd0)                    state_next = DONE;
               else if (hdr_count > 16'(MEMORY_DEPTH))    state_next = ERROR;
               else                                       state_next = LOAD;
            end
         end
         LOAD:              if (word_complete) state_next = WRITE;
         WRITE:             state_next = last_word ? DONE : LOAD;
         default:           state_next = IDLE;
      endcase
   end

   // Address/data are presented live during WRITE and held from these copies afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg    <= 16'd0;
         word_idx_reg <= '0;
         wr_addr_reg  <= '0;
         wr_data_reg  <= 32'd0;
      end else begin
         if (state_reg == HDR_HI && accept) count_reg[15:8] <= bus.byte_data;
         if (state_reg == HDR_LO && accept) begin
            count_reg[7:0] <= bus.byte_data;
            word_idx_reg   <= '0;
         end
         if (state_reg == WRITE) begin
            word_idx_reg <= word_idx_inc;
            wr_addr_reg  <= word_idx_reg[AW-1:0];
            wr_data_reg  <= asm_word;
         end
      end
   end

   always_comb begin
      ready       = (state_reg == HDR_HI) || (state_reg == HDR_LO) || (state_reg == LOAD);
      bus.wr_en   = (state_reg == WRITE);
      bus.wr_addr = (state_reg == WRITE) ? word_idx_reg[AW-1:0] : wr_addr_reg;
      bus.wr_data = (state_reg == WRITE) ? asm_word : wr_data_reg;
      cpu_reset   = (state_reg != DONE);
      done        = (state_reg == DONE);
      error       = (state_reg == ERROR);
   end

   assign bus.byte_ready = ready;

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream boot loader that sits directly upstream of the processor's program memory. It accepts a length-prefixed stream of instruction bytes, assembles them into 32-bit big-endian words and writes them sequentially into program memory. The processor is held in reset throughout the load. Reset is released only after the last word has been written, so the processor starts fetching from word 0 of a fully loaded memory.

## Interface
Parameters:
- MEMORY_DEPTH, 32: number of 32-bit words in program memory; maximum loadable word count.
- AW, $clog2(MEMORY_DEPTH): width of the word-address output.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset; forces the IDLE state and reset output values immediately.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERROR.
- byte_valid  in  1  upstream byte is present on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  program-memory write strobe, one cycle per word.
- wr_addr  out  AW  word index being written.
- wr_data  out  32  assembled instruction word.
- cpu_reset  out  1  active-high hold for the processor.
- done  out  1  load completed successfully.
- error  out  1  header word count exceeded MEMORY_DEPTH.

## Operation
- A byte transfers on any rising edge where byte_valid and byte_ready are both 1. No byte is consumed otherwise.
- Stream format: 2-byte word count N (MSB first), then 4·N bytes. Each word is sent MSB first: byte0 → wr_data[31:24], and so on.
- States:
  - IDLE: byte_ready=0, cpu_reset=1. start → HDR_HI.
  - HDR_HI: byte_ready=1. On transfer, latch count[15:8] → HDR_LO.
  - HDR_LO: byte_ready=1. On transfer, latch count[7:0]. Then:
    - full count == 0 → DONE.
    - full count > MEMORY_DEPTH → ERROR.
    - otherwise → LOAD, with byte_idx=0 and word_idx=0.
  - LOAD: byte_ready=1. Shift the byte into the word register. After the 4th byte (byte_idx==3) → WRITE.
  - WRITE: byte_ready=0, wr_en=1 for exactly one cycle, wr_addr=word_idx, wr_data=assembled word. Then word_idx+1:
    - if word_idx+1 == count → DONE.
    - else → LOAD.
  - DONE: cpu_reset=0, done=1. start → HDR_HI, which reasserts cpu_reset and clears done.
  - ERROR: cpu_reset=1, error=1, no writes. start → HDR_HI, which clears error.
- start is ignored in HDR_HI, HDR_LO, LOAD and WRITE.
- Counters:
  - byte_idx is 2 bits and wraps 3→0.
  - word_idx is AW+1 bits so it can compare against count == MEMORY_DEPTH without overflow.
  - count is 16 bits; the comparison is unsigned.
- wr_addr and wr_data are held stable outside WRITE (last values). Only wr_en qualifies them.
- Reset mid-load: the transfer is abandoned, partially written memory is left as is, cpu_reset=1 and the state returns to IDLE.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=1, done=0, error=0.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- start sampled in IDLE → byte_ready=1 on the next cycle.
- 4th byte of a word accepted at edge k → wr_en=1 during cycle k+1 → byte_ready=1 again at cycle k+2. This gives a maximum throughput of 4 bytes per 5 cycles.
- Last WRITE at cycle k → done=1 and cpu_reset=0 from cycle k+1. The processor's first fetch happens on the edge after that.
- Header count accepted at edge k with N=0 or N>MEMORY_DEPTH → done or error asserted from cycle k+1.
- byte_valid may be held high continuously; byte_ready gaps in WRITE provide back-pressure.

## Structure
- The shared package holds:
  - the state enumeration (IDLE, HDR_HI, HDR_LO, LOAD, WRITE, DONE, ERROR), encoded in 3 bits;
  - the header length constant (2 bytes);
  - the bytes-per-word constant (4).
- One sub-module, word_assembler: a 32-bit shift register with load-enable and a 2-bit byte counter. It reports word_complete when the 4th byte is shifted in.
- The top contains the FSM, the word/count registers and the output decode.

## Test plan
- Load of 2 words: stream 00 02 20 08 00 05 01 09 50 20 → wr_en pulses twice, with (addr0, 0x20080005) then (addr1, 0x01095020). done=1 and cpu_reset=0 one cycle after the second write.
- N=0: stream 00 00 → no wr_en, done=1 on the cycle after the 2nd byte.
- Oversize: MEMORY_DEPTH=32, stream 00 21 → error=1, cpu_reset stays 1, subsequent bytes not accepted (byte_ready=0). A later start plus a valid stream succeeds and clears error.
- Back-pressure: byte_valid held high for a 32-word load → exactly 32 wr_en pulses at addrs 0..31, byte_ready=0 in every WRITE cycle, no byte lost or duplicated, done after word 31.
- Reset mid-load: assert reset after 1.5 words → outputs return to reset values immediately, state IDLE, no further wr_en.
- Reload: start in DONE → cpu_reset=1 and done=0 on the next cycle; the new stream overwrites from addr 0.
